if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline: holds the PC, selects the next PC, and registers the fetched instruction into the IF/ID pipeline register. It sits directly upstream of the hazard/forward unit and decode. It consumes that unit's PCWrite, IFWrite and IFflush outputs to implement stalls and control-hazard squashes. Branch and jump targets are resolved in ID, and the block keeps saturating stall/flush counters for performance measurement.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- CNT_WIDTH, 16, width of the stall and flush counters

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- PCWrite  in  1  1 = PC may update; 0 = PC holds
- IFWrite  in  1  1 = IF/ID register may update; 0 = IF/ID holds
- IFflush  in  1  1 = squash the instruction being written into IF/ID
- Jump  in  1  ID instruction is j/jal
- Branch  in  1  ID instruction is beq-class
- Compare_Zero  in  1  ID branch comparison result (1 = taken)
- imem_addr  out  32  instruction memory address (equals PC, combinational)
- imem_data  in  32  instruction word at imem_addr (combinational read)
- ID_instr  out  32  IF/ID instruction
- ID_PC4  out  32  IF/ID PC+4
- ID_valid  out  1  IF/ID holds a real (non-squashed) instruction
- stall_count  out  CNT_WIDTH  cycles with PCWrite==0 or IFWrite==0
- flush_count  out  CNT_WIDTH  instructions squashed

## Operation
- Reset values: PC = RESET_PC; ID_instr = 0; ID_PC4 = 0; ID_valid = 0; stall_count = 0; flush_count = 0.
- pc4 = PC + 4, wrapping modulo 2^32.
- Branch target = ID_PC4 + (sign_extend(ID_instr[15:0]) << 2), modulo 2^32.
- Jump target = {ID_PC4[31:28], ID_instr[25:0], 2'b00}.
- next_pc priority:
  - Jump: jump target.
  - Otherwise, Branch & Compare_Zero: branch target.
  - Otherwise: pc4.
- PC register: at each posedge, PC <= next_pc if PCWrite==1; otherwise PC holds. The redirect is ignored while PCWrite==0, because the ID compare is not final during a stall.
- IF/ID register, at each posedge:
  - IFWrite==0: all fields hold. IFflush is ignored.
  - IFWrite==1 & IFflush==1: ID_instr <= 0 (sll $0 nop), ID_PC4 <= 0, ID_valid <= 0.
  - IFWrite==1 & IFflush==0: ID_instr <= imem_data, ID_PC4 <= pc4, ID_valid <= 1.
- Counters:
  - stall_count increments when (PCWrite==0 | IFWrite==0).
  - flush_count increments when (IFWrite & IFflush).
  - Both saturate at all-ones and never wrap.
- No internal FSM beyond these registers. The stall, redirect and squash conditions are fully determined by the inputs on each cycle.

## Timing
- imem_addr tracks PC combinationally; the memory read is zero-latency.
- Fetch-to-decode latency is 1 cycle: the word at PC appears on ID_instr after the next posedge, provided IFWrite==1.
- A taken branch or jump resolved in ID redirects PC at the same edge that squashes the wrong-path fetch. This costs exactly one bubble (ID_valid==0 for one cycle).
- Simultaneous PCWrite==0 and Jump/Branch-taken: PC holds. The redirect takes effect on the first edge with PCWrite==1.
- Simultaneous IFWrite==0 and IFflush==1: IF/ID holds and flush_count does not increment.
- PCWrite==1 with IFWrite==0 is not expected from the hazard unit. If it occurs, both rules apply independently: PC advances and IF/ID holds.
- Reset asserted mid-operation: all outputs take their reset values without waiting for a clock edge. After reset deasserts, the first fetch is from RESET_PC.

## Test plan
- Reset then 3 free-running cycles, imem returning the address as data -> ID_instr = 0x3000, 0x3004, 0x3008; ID_PC4 = 0x3004, 0x3008, 0x300C; ID_valid = 1.
- PCWrite=IFWrite=0 for 2 cycles mid-stream -> PC and ID_* frozen; stall_count += 2; flush_count unchanged.
- Branch=1, Compare_Zero=1, ID_PC4=0x3010, ID_instr[15:0]=0xFFFE -> PC = 0x3008 next cycle; ID_valid=0, ID_instr=0; flush_count += 1.
- Jump=1, ID_PC4=0x3010, ID_instr[25:0]=0x0000C40 -> PC = 0x00003100; one bubble.
- Branch taken while PCWrite=IFWrite=0 for 1 cycle, then released -> no redirect during the stall; redirect and squash on the release edge.
- Force 2^CNT_WIDTH+3 stall cycles -> stall_count = all-ones. Assert reset mid-cycle -> all outputs cleared asynchronously.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with PC, next-PC select, IF/ID register and stall/flush counters
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 PCWrite,
    input  logic                 IFWrite,
    input  logic                 IFflush,
    input  logic                 Jump,
    input  logic                 Branch,
    input  logic                 Compare_Zero,
    output logic [31:0]          imem_addr,
    input  logic [31:0]          imem_data,
    output logic [31:0]          ID_instr,
    output logic [31:0]          ID_PC4,
    output logic                 ID_valid,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);
    logic [31:0] pc, pc4, br_target, j_target, next_pc;
    logic        stall, flush;

    assign imem_addr = pc;

    // next-PC candidates; the ID-stage redirect (jump over taken branch) overrides sequential fetch
    always_comb begin
        pc4       = pc + 32'd4;
        br_target = ID_PC4 + {{14{ID_instr[15]}}, ID_instr[15:0], 2'b00};
        j_target  = {ID_PC4[31:28], ID_instr[25:0], 2'b00};
        next_pc   = Jump ? j_target : (Branch && Compare_Zero) ? br_target : pc4;
        stall     = !PCWrite || !IFWrite;
        flush     = IFWrite && IFflush;
    end

    // PC holds while stalled, which also defers any redirect until the ID compare is final
    always_ff @(posedge clk or posedge reset)
        if (reset)
            pc <= RESET_PC;
        else if (PCWrite)
            pc <= next_pc;

    // IF/ID register: hold on IFWrite low, otherwise capture the fetch or a squashed nop
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ID_instr <= '0;
            ID_PC4   <= '0;
            ID_valid <= 1'b0;
        end else if (IFWrite) begin
            ID_instr <= IFflush ? '0 : imem_data;
            ID_PC4   <= IFflush ? '0 : pc4;
            ID_valid <= !IFflush;
        end

    // saturating performance counters for stall cycles and squashed fetches
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && stall_count != '1)
                stall_count <= stall_count + CNT_WIDTH'(1);
            if (flush && flush_count != '1)
                flush_count <= flush_count + CNT_WIDTH'(1);
        end
endmodule
